// File: rtl/counter_pkg.sv
// Shared definitions for the scan up/down counter: default parameters and the
// width-generic successor function used by the counter datapath.
package counter_pkg;

    localparam int unsigned MAX_WIDTH    = 64;
    localparam int unsigned DEF_WIDTH    = 8;
    localparam bit          DEF_SATURATE = 1'b0;

    typedef struct packed {
        logic                 hit;
        logic [MAX_WIDTH-1:0] value;
    } next_t;

    // Successor of a WIDTH-bit count; hit flags an attempt to step past MAX or 0.
    function automatic next_t next_count(input logic [MAX_WIDTH-1:0] count,
                                         input int unsigned          width,
                                         input logic                 up,
                                         input logic                 sat);
        logic [MAX_WIDTH-1:0] max_v;
        logic [MAX_WIDTH-1:0] cur_v;
        next_t                res;
        if (width >= MAX_WIDTH) begin
            max_v = {MAX_WIDTH{1'b1}};
        end else begin
            max_v = (64'd1 << width) - 64'd1;
        end
        cur_v   = count & max_v;
        res.hit = up ? (cur_v == max_v) : (cur_v == {MAX_WIDTH{1'b0}});
        if (res.hit) begin
            res.value = sat ? cur_v : (up ? {MAX_WIDTH{1'b0}} : max_v);
        end else begin
            res.value = (up ? (cur_v + 64'd1) : (cur_v - 64'd1)) & max_v;
        end
        return res;
    endfunction

endpackage

// File: rtl/scan_dff_r.sv
// One-bit mux-D scan flop with asynchronous active-low reset to a fixed value.
module scan_dff_r #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic ck,
    input  logic rn,
    input  logic d,
    input  logic si,
    input  logic se,
    output logic q
);

    // Scan mux in front of the storage element; se selects the chain input.
    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            q <= RST_VAL;
        end else begin
            q <= se ? si : d;
        end
    end

endmodule

// File: rtl/scan_updown_counter.sv
// Up/down counter with load, wrap/saturate, terminal count and sticky overflow.
// Every state bit is a scan flop on one chain: scan_in -> count[0..W-1] -> ovf.
module scan_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = DEF_WIDTH,
    parameter bit               SATURATE = DEF_SATURATE,
    parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SE,
    input  logic             scan_in,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             scan_out
);

    localparam logic [WIDTH:0] RST_CHAIN = {1'b0, RST_VAL};

    logic [WIDTH:0]   chain_q_r;
    logic [WIDTH:0]   chain_d_s;
    logic [WIDTH:0]   chain_si_s;
    logic [WIDTH-1:0] count_r;
    logic             ovf_r;
    logic [WIDTH-1:0] count_d_s;
    logic             ovf_d_s;
    next_t            nxt_s;
    logic             unused_nxt_s;

    assign count_r = chain_q_r[WIDTH-1:0];
    assign ovf_r   = chain_q_r[WIDTH];

    // Successor value from the shared package function.
    always_comb begin
        nxt_s = next_count(MAX_WIDTH'(count_r), WIDTH, up, SATURATE);
    end

    // Bits above WIDTH are always zero here; fold them so nothing dangles.
    assign unused_nxt_s = ^nxt_s.value;

    // Functional priority load > en > hold; a boundary hit beats clr_ovf.
    always_comb begin
        count_d_s = count_r;
        ovf_d_s   = ovf_r;
        if (load) begin
            count_d_s = load_val;
            ovf_d_s   = ovf_r & ~clr_ovf;
        end else if (en) begin
            count_d_s = nxt_s.value[WIDTH-1:0];
            ovf_d_s   = nxt_s.hit | (ovf_r & ~clr_ovf);
        end else begin
            ovf_d_s   = ovf_r & ~clr_ovf;
        end
    end

    assign chain_d_s  = {ovf_d_s, count_d_s};
    assign chain_si_s = {chain_q_r[WIDTH-1:0], scan_in};

    for (genvar i = 0; i <= int'(WIDTH); i++) begin : g_chain
        scan_dff_r #(
            .RST_VAL(RST_CHAIN[i])
        ) u_ff (
            .ck(clk),
            .rn(rst),
            .d (chain_d_s[i]),
            .si(chain_si_s[i]),
            .se(SE),
            .q (chain_q_r[i])
        );
    end

    // Terminal count looks at the boundary in the current direction.
    always_comb begin
        if (up) begin
            tc = (count_r == {WIDTH{1'b1}});
        end else begin
            tc = (count_r == {WIDTH{1'b0}});
        end
    end

    assign count    = count_r;
    assign ovf      = ovf_r;
    assign scan_out = ovf_r;

endmodule

// File: tb/tb_scan_updown_counter.sv
// Scoreboard bench: four counter configurations share one random stimulus stream
// and are compared every cycle against an arithmetic reference model.
module tb_scan_updown_counter;

    localparam int W_C [4] = '{8, 8, 3, 16};
    localparam int S_C [4] = '{0, 1, 0, 1};
    localparam int R_C [4] = '{5, 5, 3, 16'h1234};

    logic        clk = 1'b0;
    logic        rst, se, scan_in, en, up, load, clr_ovf;
    logic [15:0] load_val;

    logic [7:0]  c0, c1;
    logic [2:0]  c2;
    logic [15:0] c3;
    logic        tc0, tc1, tc2, tc3, ov0, ov1, ov2, ov3, so0, so1, so2, so3;
    logic [15:0] act_cnt [4];
    logic [3:0]  act_tc, act_ovf, act_so;

    typedef struct packed {
        logic [3:0][15:0] cnt;
        logic [3:0]       ovf;
    } exp_t;

    exp_t sb_q[$];
    int   m_cnt [4];
    bit   m_ovf [4];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    scan_updown_counter #(.WIDTH(8), .SATURATE(1'b0), .RST_VAL(8'h05)) u_d0 (
        .clk(clk), .rst(rst), .SE(se), .scan_in(scan_in), .en(en), .up(up),
        .load(load), .load_val(load_val[7:0]), .clr_ovf(clr_ovf),
        .count(c0), .tc(tc0), .ovf(ov0), .scan_out(so0));
    scan_updown_counter #(.WIDTH(8), .SATURATE(1'b1), .RST_VAL(8'h05)) u_d1 (
        .clk(clk), .rst(rst), .SE(se), .scan_in(scan_in), .en(en), .up(up),
        .load(load), .load_val(load_val[7:0]), .clr_ovf(clr_ovf),
        .count(c1), .tc(tc1), .ovf(ov1), .scan_out(so1));
    scan_updown_counter #(.WIDTH(3), .SATURATE(1'b0), .RST_VAL(3'h3)) u_d2 (
        .clk(clk), .rst(rst), .SE(se), .scan_in(scan_in), .en(en), .up(up),
        .load(load), .load_val(load_val[2:0]), .clr_ovf(clr_ovf),
        .count(c2), .tc(tc2), .ovf(ov2), .scan_out(so2));
    scan_updown_counter #(.WIDTH(16), .SATURATE(1'b1), .RST_VAL(16'h1234)) u_d3 (
        .clk(clk), .rst(rst), .SE(se), .scan_in(scan_in), .en(en), .up(up),
        .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .count(c3), .tc(tc3), .ovf(ov3), .scan_out(so3));

    assign act_cnt[0] = {8'h00, c0};
    assign act_cnt[1] = {8'h00, c1};
    assign act_cnt[2] = {13'h0000, c2};
    assign act_cnt[3] = c3;
    assign act_tc     = {tc3, tc2, tc1, tc0};
    assign act_ovf    = {ov3, ov2, ov1, ov0};
    assign act_so     = {so3, so2, so1, so0};

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: one clock edge (or an asserted reset) applied to all configs.
    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            int maxv;
            int c;
            bit o;
            bit hit;
            maxv = (1 << W_C[i]) - 1;
            c    = m_cnt[i];
            o    = m_ovf[i];
            if (!rst) begin
                c = R_C[i];
                o = 1'b0;
            end else if (se) begin
                o = ((c >> (W_C[i] - 1)) & 1) != 0;
                c = ((c << 1) | int'(scan_in)) & maxv;
            end else if (load) begin
                c = int'(load_val) & maxv;
                if (clr_ovf) o = 1'b0;
            end else if (en) begin
                hit = up ? (c == maxv) : (c == 0);
                if (hit) begin
                    o = 1'b1;
                    if (S_C[i] == 0) c = up ? 0 : maxv;
                end else begin
                    c = up ? c + 1 : c - 1;
                    if (clr_ovf) o = 1'b0;
                end
            end else if (clr_ovf) begin
                o = 1'b0;
            end
            m_cnt[i] = c;
            m_ovf[i] = o;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.cnt[i] = 16'(m_cnt[i]);
            e.ovf[i] = m_ovf[i];
        end
        sb_q.push_back(e);
    endtask

    // Called at negedge+1: apply inputs, take one edge, return at next negedge+1.
    task automatic drive(input logic rst_v, input logic se_v, input logic si_v,
                         input logic en_v, input logic up_v, input logic load_v,
                         input logic [15:0] lv_v, input logic clr_v);
        rst = rst_v; se = se_v; scan_in = si_v; en = en_v; up = up_v;
        load = load_v; load_val = lv_v; clr_ovf = clr_v;
        if (!rst_v) model_step();
        @(posedge clk);
        model_step();
        push_expected();
        @(negedge clk);
        #1;
    endtask

    // Monitor: each negedge the registered outputs are compared with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int i = 0; i < 4; i++) begin
                int  maxv;
                logic exp_tc;
                maxv   = (1 << W_C[i]) - 1;
                exp_tc = up ? (int'(e.cnt[i]) == maxv) : (e.cnt[i] == 16'h0000);
                check($sformatf("dut%0d count", i), 64'(act_cnt[i]), 64'(e.cnt[i]));
                check($sformatf("dut%0d ovf", i), 64'(act_ovf[i]), 64'(e.ovf[i]));
                check($sformatf("dut%0d scan_out", i), 64'(act_so[i]), 64'(e.ovf[i]));
                check($sformatf("dut%0d tc", i), 64'(act_tc[i]), 64'(exp_tc));
            end
        end
    end

    initial begin
        logic [8:0]  bits;
        logic [15:0] lv;
        rst = 1'b0; se = 1'b0; scan_in = 1'b0; en = 1'b0; up = 1'b0;
        load = 1'b0; load_val = 16'h0000; clr_ovf = 1'b0;
        model_step();
        @(negedge clk);
        #1;
        check("reset count d0", 64'(c0), 64'h05);
        check("reset ovf d0", 64'(ov0), 64'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);

        // Up wrap on d0, up saturate on d1.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("wrap FF", 64'(c0), 64'hFF);
        check("wrap tc", 64'(tc0), 64'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("wrap 00", 64'(c0), 64'h00);
        check("wrap ovf", 64'(ov0), 64'h1);
        check("sat up hold", 64'(c1), 64'hFF);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("wrap 01", 64'(c0), 64'h01);

        // Down saturate on d1.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        check("clr ovf", 64'(ov1), 64'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("sat dn 00", 64'(c1), 64'h00);
        check("sat dn tc", 64'(tc1), 64'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("sat dn hold", 64'(c1), 64'h00);
        check("sat dn ovf", 64'(ov1), 64'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("sat dn stay", 64'(c1), 64'h00);

        // Priority: load over en; boundary set beats clr_ovf.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h003C, 1'b0);
        check("load over en", 64'(c0), 64'h3C);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00FF, 1'b1);
        check("load clr ovf", 64'(ov0), 64'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        check("set beats clr cnt", 64'(c0), 64'h00);
        check("set beats clr ovf", 64'(ov0), 64'h1);

        // Scan shift in with functional inputs active, then shift out.
        bits = 9'b1_0100_1101;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b1, bits[k], 1'b1, 1'b1, 1'b1, 16'($urandom), 1'b1);
        end
        check("scan count", 64'(c0), 64'h65);
        check("scan ovf", 64'(ov0), 64'h1);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("scan out %0d", k), 64'(so0), 64'(bits[k]));
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'($urandom), 1'b0);
        end

        // Reset asserted mid-count takes effect without a clock edge.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        rst = 1'b0;
        model_step();
        #1;
        check("async rst count d0", 64'(c0), 64'h05);
        check("async rst ovf d0", 64'(ov0), 64'h0);
        check("async rst count d2", 64'(c2), 64'h3);
        check("async rst count d3", 64'(c3), 64'h1234);
        @(posedge clk);
        model_step();
        push_expected();
        @(negedge clk);
        #1;

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 4))
                0:       lv = 16'hFFFF;
                1:       lv = 16'hFFFE;
                2:       lv = 16'h0000;
                3:       lv = 16'h0001;
                default: lv = 16'($urandom);
            endcase
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  lv, ($urandom_range(0, 7) == 0));
        end

        check("scoreboard drained", 64'(sb_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
